// File: rtl/bitstream_reader.sv
// MSB-first bit window over a byte stream: peek WIDTH bits, consume 0..WIDTH per cycle.
// Latency 1 cycle for refill and flush; in_ready is registered-only, flush_ready waits for enough bits.
module bitstream_reader #(
  parameter  int WIDTH    = 32,
  parameter  int IN_BYTES = 1,
  localparam int NW       = $clog2(WIDTH + 1),
  localparam int INW      = 8 * IN_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INW-1:0]   in_data,
  input  logic             in_last,
  input  logic             flush_valid,
  output logic             flush_ready,
  input  logic [NW-1:0]    flush_n,
  input  logic             flush_align,
  output logic [WIDTH-1:0] show_bits,
  output logic [NW-1:0]    incnt,
  output logic [31:0]      bits_consumed,
  output logic             eos,
  output logic             done
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [NW-1:0] W_N   = NW'(WIDTH);
  localparam logic [NW-1:0] INW_N = NW'(INW);
  localparam logic [NW-1:0] ROOM  = NW'(WIDTH - INW);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   win_q, win_d;
  logic [NW-1:0]      incnt_q, incnt_d;
  logic [31:0]        cons_q, cons_d;
  logic               eos_q, eos_d;

  logic [NW-1:0]      n_lim, flush_cnt;
  logic               in_fire, flush_fire;
  logic [WIDTH-1:0]   in_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      win_q   <= '0;
      incnt_q <= '0;
      cons_q  <= '0;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      incnt_q <= incnt_d;
      cons_q  <= cons_d;
      eos_q   <= eos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && in_fire && in_last) state_d = DRAIN;
  end

  always_comb begin
    n_lim     = (flush_n > W_N) ? W_N : flush_n;
    flush_cnt = flush_align ? {{(NW-3){1'b0}}, incnt_q[2:0]} : n_lim;
    in_ready    = !rst && state_q == RUN && incnt_q <= ROOM;
    flush_ready = !rst && (state_q == DRAIN || flush_cnt <= incnt_q);
    show_bits     = win_q;
    incnt         = incnt_q;
    bits_consumed = cons_q;
    eos           = eos_q;
    done          = state_q == DRAIN && incnt_q == '0;
  end

  // The new beat lands just below whatever survives this cycle's flush.
  always_comb begin
    in_fire    = in_valid && in_ready;
    flush_fire = flush_valid && flush_ready;
    in_ext     = {in_data, {(WIDTH-INW){1'b0}}};
    win_d      = win_q;
    incnt_d    = incnt_q;
    cons_d     = cons_q;
    eos_d      = eos_q;
    if (flush_fire) begin
      win_d   = win_q << flush_cnt;
      incnt_d = (flush_cnt > incnt_q) ? '0 : incnt_q - flush_cnt;
      cons_d  = cons_q + 32'(flush_cnt);
    end
    if (in_fire) begin
      win_d   = win_d | (in_ext >> incnt_d);
      incnt_d = incnt_d + INW_N;
      if (in_last) eos_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_bitstream_reader.sv
// Bench for bitstream_reader (WIDTH=32, IN_BYTES=1): bit-queue model feeds a scoreboard of expected states.
module tb_bitstream_reader;
  localparam int WIDTH = 32;
  localparam int NW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_data;
  logic             flush_valid, flush_ready, flush_align;
  logic [NW-1:0]    flush_n;
  logic [WIDTH-1:0] show_bits;
  logic [NW-1:0]    incnt;
  logic [31:0]      bits_consumed;
  logic             eos, done;

  bitstream_reader #(.WIDTH(WIDTH), .IN_BYTES(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_n(flush_n),
    .flush_align(flush_align), .show_bits(show_bits), .incnt(incnt),
    .bits_consumed(bits_consumed), .eos(eos), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   show;
    logic [NW-1:0] cnt;
    logic [31:0]   cons;
    logic          eos, done, irdy, frdy;
  } st_t;

  st_t         sb[$];
  st_t         got, e;
  bit          mbits[$];
  logic [31:0] mcons;
  bit          mdrain;
  int          total = 0;
  int          bad   = 0;

  // Drive one cycle, advance the model, push its expected state, then capture the DUT state.
  task automatic drive(input logic iv, input logic [7:0] d, input logic last,
                       input logic fv, input logic [NW-1:0] fn, input logic fa);
    st_t x;
    int  n;
    bit  irdy, frdy;
    logic oi, of;
    in_valid = iv; in_data = d; in_last = last;
    flush_valid = fv; flush_n = fn; flush_align = fa;
    #1;
    oi = in_ready; of = flush_ready;
    n    = fa ? (mbits.size() % 8) : (int'(fn) > WIDTH ? WIDTH : int'(fn));
    frdy = mdrain || n <= mbits.size();
    irdy = !mdrain && mbits.size() <= WIDTH - 8;
    if (fv && frdy) begin
      for (int i = 0; i < n; i++) if (mbits.size() > 0) void'(mbits.pop_front());
      mcons += 32'(n);
    end
    if (iv && irdy) begin
      for (int i = 7; i >= 0; i--) mbits.push_back(d[i]);
      if (last) mdrain = 1'b1;
    end
    x.show = '0;
    for (int i = 0; i < WIDTH && i < mbits.size(); i++) x.show[WIDTH-1-i] = mbits[i];
    x.cnt  = NW'(mbits.size());
    x.cons = mcons;
    x.eos  = mdrain;
    x.done = mdrain && mbits.size() == 0;
    x.irdy = irdy;
    x.frdy = frdy;
    sb.push_back(x);
    @(posedge clk); #1;
    got = {show_bits, incnt, bits_consumed, eos, done, oi, of};
    in_valid = 0; in_last = 0; flush_valid = 0; flush_align = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_data = 8'hFF; flush_valid = 1; flush_n = '0; flush_align = 0; in_last = 0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (flush_ready !== 1'b0) begin bad++; $display("FAIL rst_flush_ready got=%b exp=0", flush_ready); end
    @(posedge clk); #1;
    rst = 0; in_valid = 0; flush_valid = 0;
    mbits.delete(); mcons = '0; mdrain = 0; sb.delete();
    total++;
    if ({show_bits, incnt, bits_consumed, eos, done} !== '0) begin
      bad++; $display("FAIL rst_state got=%h/%0d/%0d/%b/%b exp=0", show_bits, incnt, bits_consumed, eos, done);
    end
  endtask

  task automatic test_fill();
    logic [7:0] b[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], 0, 0, '0, 0);
      e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL fill_sb got=%h exp=%h", got, e); end
    end
    total++; if (show_bits !== 32'h12345678 || incnt !== 6'd32) begin
      bad++; $display("FAIL fill_window got=%h/%0d exp=12345678/32", show_bits, incnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_flush();
    drive(0, 8'h00, 0, 1, 6'd12, 0);
    e = sb.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL flush_sb got=%h exp=%h", got, e); end
    total++; if (show_bits !== 32'h45678000 || incnt !== 6'd20 || bits_consumed !== 32'd12) begin
      bad++; $display("FAIL flush12 got=%h/%0d/%0d exp=45678000/20/12", show_bits, incnt, bits_consumed); end
    drive(1, 8'h9A, 0, 0, '0, 0);
    e = sb.pop_front();
    total++; if (show_bits !== 32'h456789A0 || incnt !== 6'd28 || got !== e) begin
      bad++; $display("FAIL refill got=%h/%0d exp=456789A0/28", show_bits, incnt); end
  endtask

  task automatic test_align();
    drive(0, 8'h00, 0, 1, 6'd5, 1);
    e = sb.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL align_sb got=%h exp=%h", got, e); end
    total++; if (show_bits !== 32'h56789A00 || incnt !== 6'd24 || bits_consumed !== 32'd16) begin
      bad++; $display("FAIL align got=%h/%0d/%0d exp=56789A00/24/16", show_bits, incnt, bits_consumed); end
  endtask

  task automatic test_back_to_back();
    drive(1, 8'hBC, 0, 1, 6'd8, 0);
    e = sb.pop_front();
    total++; if (got !== e || show_bits !== 32'h789ABC00 || incnt !== 6'd24 || bits_consumed !== 32'd24) begin
      bad++; $display("FAIL simul got=%h/%0d/%0d exp=789ABC00/24/24", show_bits, incnt, bits_consumed); end
  endtask

  task automatic test_wait();
    drive(0, 8'h00, 0, 1, 6'd8, 0);
    e = sb.pop_front();
    total++; if (got !== e || show_bits !== 32'h9ABC0000 || incnt !== 6'd16) begin
      bad++; $display("FAIL wait_pre got=%h/%0d exp=9ABC0000/16", show_bits, incnt); end
    drive(0, 8'h00, 0, 1, 6'd20, 0);
    e = sb.pop_front();
    total++; if (got.frdy !== 1'b0 || got !== e) begin
      bad++; $display("FAIL wait_block got=%b/%0d exp=0/16", got.frdy, incnt); end
    drive(1, 8'hDE, 0, 1, 6'd20, 0);
    e = sb.pop_front();
    total++; if (got !== e || show_bits !== 32'h9ABCDE00 || incnt !== 6'd24) begin
      bad++; $display("FAIL wait_refill got=%h/%0d exp=9ABCDE00/24", show_bits, incnt); end
    drive(0, 8'h00, 0, 1, 6'd20, 0);
    e = sb.pop_front();
    total++; if (got !== e || show_bits !== 32'hE0000000 || incnt !== 6'd4 || bits_consumed !== 32'd52) begin
      bad++; $display("FAIL wait_accept got=%h/%0d/%0d exp=E0000000/4/52", show_bits, incnt, bits_consumed); end
  endtask

  task automatic test_drain();
    drive(1, 8'hF0, 1, 0, '0, 0);
    e = sb.pop_front();
    total++; if (got !== e || show_bits !== 32'hEF000000 || incnt !== 6'd12 || eos !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL last_beat got=%h/%0d/%b/%b exp=EF000000/12/1/0", show_bits, incnt, eos, in_ready); end
    drive(0, 8'h00, 0, 1, 6'd4, 0);
    e = sb.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL drain4 got=%h exp=%h", got, e); end
    drive(0, 8'h00, 0, 1, 6'd32, 0);
    e = sb.pop_front();
    total++; if (got !== e || show_bits !== '0 || incnt !== '0 || bits_consumed !== 32'd88 || done !== 1'b1) begin
      bad++; $display("FAIL drain32 got=%h/%0d/%0d/%b exp=0/0/88/1", show_bits, incnt, bits_consumed, done); end
    drive(0, 8'h00, 0, 1, 6'd8, 0);
    e = sb.pop_front();
    total++; if (got !== e || bits_consumed !== 32'd96 || incnt !== '0) begin
      bad++; $display("FAIL drain_pad got=%0d/%0d exp=96/0", bits_consumed, incnt); end
  endtask

  task automatic test_random();
    logic          fv = 0, fa = 0, iv, last;
    logic [NW-1:0] fn = '0;
    bit            hold = 0;
    int            beats = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        fv = 1'($urandom % 2);
        fn = NW'($urandom_range(0, 40));
        fa = ($urandom % 8) == 0;
      end
      iv   = 1'($urandom % 2);
      last = beats == 79;
      drive(iv, 8'($urandom), last, fv, fn, fa);
      e = sb.pop_front();
      hold = fv && !e.frdy;
      if (iv && e.irdy) beats++;
      total++; if (got !== e) begin bad++; $display("FAIL rand_c%0d got=%h exp=%h", c, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush();
    test_align();
    test_back_to_back();
    test_wait();
    test_drain();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
